// File: rtl/multicycle_control_fsm_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states, datapath select codes
// and the immediate-format decode used by both control units.
package riscv_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        EXECU    = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        JALR     = 4'd12,
        JALRPC   = 4'd13,
        TRAP     = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_PC        = 2'b11
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // R-type and unknown opcodes fall back to the I format (no immediate used).
    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        imm_src_t imm;
        imm = IMM_I;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the
// instruction register / datapath / memory port (slave).
interface multicycle_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op_i;
    logic             take_branch_i;
    logic             mem_ready_i;
    logic             mem_req_o;
    logic             adr_src_o;
    logic             mem_write_o;
    logic             ir_write_o;
    logic             pc_write_o;
    logic             branch_o;
    logic             reg_write_o;
    logic [1:0]       result_src_o;
    logic [1:0]       alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       alu_op_o;
    logic [2:0]       imm_src_o;
    logic             trap_o;
    logic [CNT_W-1:0] retired_o;
    logic [3:0]       state_o;

    modport master (
        input  op_i, take_branch_i, mem_ready_i,
        output mem_req_o, adr_src_o, mem_write_o, ir_write_o, pc_write_o,
               branch_o, reg_write_o, result_src_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, imm_src_o, trap_o, retired_o, state_o
    );

    modport slave (
        output op_i, take_branch_i, mem_ready_i,
        input  mem_req_o, adr_src_o, mem_write_o, ir_write_o, pc_write_o,
               branch_o, reg_write_o, result_src_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, imm_src_o, trap_o, retired_o, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// illegal-opcode trap and retired-instruction counter.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter bit          MEM_HANDSHAKE   = 1'b1,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master bus
);

    state_t           state, next_state;
    logic [CNT_W-1:0] retired;
    logic             ready, retire;

    logic        mem_req, adr_src, mem_write, ir_write, pc_update, branch, reg_write;
    result_src_t result_src;
    src_a_t      src_a;
    src_b_t      src_b;
    alu_op_t     alu_op;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready_i : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            FETCH:    if (ready) next_state = DECODE;
            DECODE: begin
                case (bus.op_i)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    OP_LUI, OP_AUIPC:  next_state = EXECU;
                    default:           next_state = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEMADR:   next_state = bus.op_i[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (ready) next_state = MEMWB;
            MEMWRITE: begin
                if (ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end
            end
            EXECR, EXECI, EXECU, JAL: next_state = ALUWB;
            JALR:     next_state = JALRPC;
            MEMWB, ALUWB, BRANCH, JALRPC: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        alu_op     = ALU_ADD;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = ready;
                pc_update  = ready;
            end
            DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
            end
            MEMADR: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                src_a  = SRCA_RS1;
                alu_op = ALU_FUNCT;
            end
            EXECI: begin
                src_a  = SRCA_RS1;
                src_b  = SRCB_IMM;
                alu_op = ALU_FUNCT;
            end
            EXECU: begin
                src_a = bus.op_i[5] ? SRCA_ZERO : SRCA_OLDPC;
                src_b = SRCB_IMM;
            end
            ALUWB:  reg_write = 1'b1;
            BRANCH: begin
                src_a  = SRCA_RS1;
                alu_op = ALU_BRANCH;
                branch = 1'b1;
            end
            JAL: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_update = 1'b1;
            end
            // rd gets the already-incremented PC; the jump target is written next cycle.
            JALR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                result_src = RES_PC;
                reg_write  = 1'b1;
            end
            JALRPC:  pc_update = 1'b1;
            default: ;
        endcase
    end

    // Reset holds every control low even though the state register already reads FETCH.
    assign bus.mem_req_o    = rst_n & mem_req;
    assign bus.adr_src_o    = rst_n & adr_src;
    assign bus.mem_write_o  = rst_n & mem_write;
    assign bus.ir_write_o   = rst_n & ir_write;
    assign bus.pc_write_o   = rst_n & (pc_update | (branch & bus.take_branch_i));
    assign bus.branch_o     = rst_n & branch;
    assign bus.reg_write_o  = rst_n & reg_write;
    assign bus.result_src_o = rst_n ? result_src : '0;
    assign bus.alu_src_a_o  = rst_n ? src_a : '0;
    assign bus.alu_src_b_o  = rst_n ? src_b : '0;
    assign bus.alu_op_o     = rst_n ? alu_op : '0;
    assign bus.imm_src_o    = (rst_n && state != TRAP) ? imm_src_of(bus.op_i) : '0;
    assign bus.trap_o       = rst_n && (state == TRAP);
    assign bus.retired_o    = retired;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expectations go through a
// scoreboard queue and are compared against the DUT outputs mid-cycle.
module tb_multicycle_control_fsm;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(32)) if_a ();
    multicycle_control_fsm_if #(.CNT_W(4))  if_b ();

    multicycle_control_fsm #(.CNT_W(32)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(if_a));
    multicycle_control_fsm #(.CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if_b));

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [2:0]  imm;
        logic        chk_imm;
        logic        trap;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];

    function automatic logic [14:0] pack(input logic mr, as, mw, iw, pw, br, rw,
                                         input logic [1:0] res, sa, sbv, ao);
        return {mr, as, mw, iw, pw, br, rw, res, sa, sbv, ao};
    endfunction

    function automatic logic [14:0] model_ctl(input state_t st, input logic op5,
                                              input logic rdy, input logic tb);
        case (st)
            FETCH:    return pack(1,0,0,rdy,rdy,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
            DECODE:   return pack(0,0,0,0,0,0,0,   2'b00, 2'b01, 2'b01, 2'b00);
            MEMADR:   return pack(0,0,0,0,0,0,0,   2'b00, 2'b10, 2'b01, 2'b00);
            MEMREAD:  return pack(1,1,0,0,0,0,0,   2'b00, 2'b00, 2'b00, 2'b00);
            MEMWB:    return pack(0,0,0,0,0,0,1,   2'b01, 2'b00, 2'b00, 2'b00);
            MEMWRITE: return pack(1,1,1,0,0,0,0,   2'b00, 2'b00, 2'b00, 2'b00);
            EXECR:    return pack(0,0,0,0,0,0,0,   2'b00, 2'b10, 2'b00, 2'b10);
            EXECI:    return pack(0,0,0,0,0,0,0,   2'b00, 2'b10, 2'b01, 2'b10);
            EXECU:    return pack(0,0,0,0,0,0,0,   2'b00, op5 ? 2'b11 : 2'b01, 2'b01, 2'b00);
            ALUWB:    return pack(0,0,0,0,0,0,1,   2'b00, 2'b00, 2'b00, 2'b00);
            BRANCH:   return pack(0,0,0,0,tb,1,0,  2'b00, 2'b10, 2'b00, 2'b01);
            JAL:      return pack(0,0,0,0,1,0,0,   2'b00, 2'b01, 2'b10, 2'b00);
            JALR:     return pack(0,0,0,0,0,0,1,   2'b11, 2'b10, 2'b01, 2'b00);
            JALRPC:   return pack(0,0,0,0,1,0,0,   2'b00, 2'b00, 2'b00, 2'b00);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [2:0] model_imm(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [14:0] dut_ctl();
        return {if_a.mem_req_o, if_a.adr_src_o, if_a.mem_write_o, if_a.ir_write_o,
                if_a.pc_write_o, if_a.branch_o, if_a.reg_write_o, if_a.result_src_o,
                if_a.alu_src_a_o, if_a.alu_src_b_o, if_a.alu_op_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic rdy, input logic tb);
        if_a.op_i = op; if_a.mem_ready_i = rdy; if_a.take_branch_i = tb;
        if_b.op_i = op; if_b.mem_ready_i = rdy; if_b.take_branch_i = tb;
    endtask

    // Called at a negedge: drive inputs, queue the expectation, compare mid-cycle.
    task automatic step(input string tag, input state_t st, input logic [6:0] op,
                        input logic rdy, input logic tb, input logic [31:0] ret);
        exp_t e;
        drive(op, rdy, tb);
        e.tag = tag; e.st = st; e.ctl = model_ctl(st, op[5], rdy, tb);
        e.imm = model_imm(op); e.chk_imm = (st != TRAP);
        e.trap = (st == TRAP); e.ret = ret;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".state"},   32'(if_a.state_o),   32'(e.st));
        chk({e.tag, ".ctl"},     32'(dut_ctl()),      32'(e.ctl));
        chk({e.tag, ".trap"},    32'(if_a.trap_o),    32'(e.trap));
        chk({e.tag, ".retired"}, if_a.retired_o,      e.ret);
        if (e.chk_imm)
            chk({e.tag, ".imm"}, 32'(if_a.imm_src_o), 32'(e.imm));
        @(negedge clk);
    endtask

    localparam logic [6:0] ADD = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011,
                           BEQ = 7'b1100011, JALR_OP = 7'b1100111, JAL_OP = 7'b1101111,
                           LUI = 7'b0110111, AUIPC = 7'b0010111, ADDI = 7'b0010011,
                           BAD = 7'b1111111;

    initial begin
        int unsigned r;
        rst_n = 1'b0;
        drive(ADD, 1'b1, 1'b0);
        #1;
        chk("reset.state",   32'(if_a.state_o), 32'(FETCH));
        chk("reset.ctl",     32'(dut_ctl()),    32'd0);
        chk("reset.trap",    32'(if_a.trap_o),  32'd0);
        chk("reset.retired", if_a.retired_o,    32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        r = 0;

        step("add.f", FETCH,  ADD, 1, 0, r);
        step("add.d", DECODE, ADD, 1, 0, r);
        step("add.x", EXECR,  ADD, 1, 0, r);
        step("add.w", ALUWB,  ADD, 1, 0, r); r++;

        step("lw.stall", FETCH, LW, 0, 0, r);
        step("lw.f",     FETCH, LW, 1, 0, r);
        step("lw.d",     DECODE, LW, 1, 0, r);
        step("lw.a",     MEMADR, LW, 0, 0, r);
        for (int i = 0; i < 3; i++)
            step("lw.wait", MEMREAD, LW, 0, 0, r);
        step("lw.rd",    MEMREAD, LW, 1, 0, r);
        step("lw.wb",    MEMWB,   LW, 0, 0, r); r++;

        step("sw.f",    FETCH,    SW, 1, 0, r);
        step("sw.d",    DECODE,   SW, 1, 0, r);
        step("sw.a",    MEMADR,   SW, 1, 0, r);
        step("sw.wait", MEMWRITE, SW, 0, 0, r);
        step("sw.wr",   MEMWRITE, SW, 1, 0, r); r++;

        step("beq1.f", FETCH,  BEQ, 1, 0, r);
        step("beq1.d", DECODE, BEQ, 1, 1, r);
        step("beq1.b", BRANCH, BEQ, 1, 1, r); r++;
        step("beq0.f", FETCH,  BEQ, 1, 0, r);
        step("beq0.d", DECODE, BEQ, 1, 0, r);
        step("beq0.b", BRANCH, BEQ, 1, 0, r); r++;

        step("jalr.f",  FETCH,  JALR_OP, 1, 0, r);
        step("jalr.d",  DECODE, JALR_OP, 1, 0, r);
        step("jalr.rd", JALR,   JALR_OP, 1, 0, r);
        step("jalr.pc", JALRPC, JALR_OP, 1, 0, r); r++;

        step("jal.f", FETCH,  JAL_OP, 1, 0, r);
        step("jal.d", DECODE, JAL_OP, 1, 0, r);
        step("jal.j", JAL,    JAL_OP, 1, 0, r);
        step("jal.w", ALUWB,  JAL_OP, 1, 0, r); r++;

        step("lui.f",   FETCH,  LUI, 1, 0, r);
        step("lui.d",   DECODE, LUI, 1, 0, r);
        step("lui.x",   EXECU,  LUI, 1, 0, r);
        step("lui.w",   ALUWB,  LUI, 1, 0, r); r++;
        step("auipc.f", FETCH,  AUIPC, 1, 0, r);
        step("auipc.d", DECODE, AUIPC, 1, 0, r);
        step("auipc.x", EXECU,  AUIPC, 1, 0, r);
        step("auipc.w", ALUWB,  AUIPC, 1, 0, r); r++;

        step("addi.f", FETCH,  ADDI, 1, 0, r);
        step("addi.d", DECODE, ADDI, 1, 0, r);
        step("addi.x", EXECI,  ADDI, 1, 0, r);
        step("addi.w", ALUWB,  ADDI, 1, 0, r); r++;

        step("bad.f", FETCH,  BAD, 1, 0, r);
        step("bad.d", DECODE, BAD, 1, 0, r);
        for (int i = 0; i < 20; i++)
            step("trap.hold", TRAP, BAD, 1'(i), 1'(i >> 1), r);

        // Asynchronous reset asserted mid-cycle, away from any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("areset.state",   32'(if_a.state_o), 32'(FETCH));
        chk("areset.ctl",     32'(dut_ctl()),    32'd0);
        chk("areset.trap",    32'(if_a.trap_o),  32'd0);
        chk("areset.retired", if_a.retired_o,    32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step("wrap.f", FETCH,  ADDI, 1, 0, 32'(i));
            step("wrap.d", DECODE, ADDI, 1, 0, 32'(i));
            step("wrap.x", EXECI,  ADDI, 1, 0, 32'(i));
            step("wrap.w", ALUWB,  ADDI, 1, 0, 32'(i));
            if (i == 14) begin
                #1 chk("wrap4.max", 32'(if_b.retired_o), 32'd15);
            end
        end
        #1;
        chk("wrap4.retired", 32'(if_b.retired_o), 32'd1);
        chk("wrap32.retired", if_a.retired_o,     32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
